// File: rtl/final_project_xmit_pkg.sv
// Shared types and defaults for the final_project serial transmit path.
// Holds the transmitter FSM state encoding and the default word width.
package final_project_xmit_pkg;

    localparam int unsigned DefaultWordSize = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWaiting,
        StSending
    } xmit_state_e;

endpackage

// File: rtl/final_project_xmit_if.sv
// Parallel-side handshake and serial-line bundle for final_project_xmit.
// The master modport drives the byte and its strobes; the slave is the transmitter.
interface final_project_xmit_if import final_project_xmit_pkg::*; #(
    parameter int unsigned WORD_SIZE = DefaultWordSize
) ();

    logic [WORD_SIZE-1:0] i_data_bus;
    logic                 i_load_xmt_data;
    logic                 i_byte_rdy;
    logic                 i_T_byte;
    logic                 o_serial_out;
    logic                 o_busy;

    modport master (
        output i_data_bus,
        output i_load_xmt_data,
        output i_byte_rdy,
        output i_T_byte,
        input  o_serial_out,
        input  o_busy
    );

    modport slave (
        input  i_data_bus,
        input  i_load_xmt_data,
        input  i_byte_rdy,
        input  i_T_byte,
        output o_serial_out,
        output o_busy
    );

endinterface

// File: rtl/final_project_xmit_bit_timer.sv
// Clocks-per-bit divider: emits a one-cycle bit_tick every CLKS_PER_BIT enabled cycles.
// With CLKS_PER_BIT=1 the counter stays at zero and the tick follows i_enable.
module final_project_xmit_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;

    always_comb begin
        clk_cnt_d = clk_cnt_q;
        if (i_clear) begin
            clk_cnt_d = '0;
        end else if (i_enable) begin
            clk_cnt_d = (clk_cnt_q == LastCnt) ? '0 : clk_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

    assign o_bit_tick = i_enable && (clk_cnt_q == LastCnt);

endmodule

// File: rtl/final_project_xmit.sv
// UART-style byte transmitter: hold register, staged frame shift register, LSB-first
// shift-out with start bit 0 and stop bit 1. Line idles high.
module final_project_xmit import final_project_xmit_pkg::*; #(
    parameter int unsigned WORD_SIZE    = DefaultWordSize,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input logic                 i_clk,
    input logic                 i_reset,
    final_project_xmit_if.slave bus
);

    localparam int unsigned CntW = $clog2(WORD_SIZE + 2);
    localparam logic [CntW-1:0] LastBit = CntW'(WORD_SIZE + 1);

    xmit_state_e          state_q, state_d;
    logic [WORD_SIZE-1:0] data_reg_q, data_reg_d;
    logic [WORD_SIZE:0]   shift_reg_q, shift_reg_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 start_frame;
    logic                 bit_tick;

    final_project_xmit_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (start_frame),
        .i_enable   (state_q == StSending),
        .o_bit_tick (bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        data_reg_d  = data_reg_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        start_frame = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_load_xmt_data) data_reg_d = bus.i_data_bus;
                // Staging reads the pre-load data_reg, so load+byte_rdy together sends the old byte.
                if (bus.i_byte_rdy) begin
                    shift_reg_d = {data_reg_q, 1'b1};
                    state_d     = StWaiting;
                end
            end
            StWaiting: begin
                if (bus.i_load_xmt_data) data_reg_d = bus.i_data_bus;
                if (bus.i_byte_rdy) shift_reg_d = {data_reg_q, 1'b1};
                if (bus.i_T_byte) begin
                    shift_reg_d[0] = 1'b0;
                    bit_cnt_d      = '0;
                    start_frame    = 1'b1;
                    state_d        = StSending;
                end
            end
            StSending: begin
                if (bit_tick) begin
                    // At LastBit the stop bit has had its full period on the line.
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        shift_reg_d = {1'b1, shift_reg_q[WORD_SIZE:1]};
                        bit_cnt_d   = bit_cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            data_reg_q  <= '0;
            shift_reg_q <= '1;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_reg_q  <= data_reg_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign bus.o_serial_out = shift_reg_q[0];
    assign bus.o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_final_project_xmit.sv
// Directed bench for final_project_xmit: one instance at CLKS_PER_BIT=1, one at 4.
module tb_final_project_xmit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    final_project_xmit_if #(.WORD_SIZE(8)) bus1 ();
    final_project_xmit_if #(.WORD_SIZE(8)) bus4 ();

    final_project_xmit #(.WORD_SIZE(8), .CLKS_PER_BIT(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1)
    );

    final_project_xmit #(.WORD_SIZE(8), .CLKS_PER_BIT(4)) dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.i_data_bus = '0; bus1.i_load_xmt_data = 0; bus1.i_byte_rdy = 0; bus1.i_T_byte = 0;
        bus4.i_data_bus = '0; bus4.i_load_xmt_data = 0; bus4.i_byte_rdy = 0; bus4.i_T_byte = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // load -> byte_rdy -> T_byte on consecutive cycles; returns in the first start-bit cycle
    task automatic start1(input logic [7:0] b);
        bus1.i_data_bus = b; bus1.i_load_xmt_data = 1'b1;
        step();
        bus1.i_load_xmt_data = 1'b0; bus1.i_byte_rdy = 1'b1;
        step();
        bus1.i_byte_rdy = 1'b0; bus1.i_T_byte = 1'b1;
        step();
        bus1.i_T_byte = 1'b0;
    endtask

    task automatic start4(input logic [7:0] b);
        bus4.i_data_bus = b; bus4.i_load_xmt_data = 1'b1;
        step();
        bus4.i_load_xmt_data = 1'b0; bus4.i_byte_rdy = 1'b1;
        step();
        bus4.i_byte_rdy = 1'b0; bus4.i_T_byte = 1'b1;
        step();
        bus4.i_T_byte = 1'b0;
    endtask

    // samples 10 line bits starting in the current cycle; ends in the stop-bit cycle
    task automatic capture1(output logic [9:0] line);
        for (int i = 0; i < 10; i++) begin
            line[i] = bus1.o_serial_out;
            if (i < 9) step();
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus1.o_serial_out !== 1'b1 || bus1.o_busy !== 1'b0 ||
                bus4.o_serial_out !== 1'b1 || bus4.o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: line1=%b busy1=%b line4=%b busy4=%b, want 1 0 1 0",
                         i, bus1.o_serial_out, bus1.o_busy, bus4.o_serial_out, bus4.o_busy);
            end
            step();
        end
    endtask

    task automatic test_frame_a5();
        int exp_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        bus1.i_data_bus = 8'hA5; bus1.i_load_xmt_data = 1'b1;
        step();
        bus1.i_load_xmt_data = 1'b0; bus1.i_byte_rdy = 1'b1;
        step();
        n_tests++;
        if (bus1.o_busy !== 1'b1 || bus1.o_serial_out !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_waiting: busy=%b line=%b, want 1 1", bus1.o_busy, bus1.o_serial_out);
        end
        bus1.i_byte_rdy = 1'b0; bus1.i_T_byte = 1'b1;
        step();
        bus1.i_T_byte = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (bus1.o_serial_out !== 1'(exp_seq[i]) || bus1.o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL a5_bit%0d: line=%b busy=%b, want %0d 1",
                         i, bus1.o_serial_out, bus1.o_busy, exp_seq[i]);
            end
            step();
        end
        n_tests++;
        if (bus1.o_serial_out !== 1'b1 || bus1.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done: line=%b busy=%b, want 1 0", bus1.o_serial_out, bus1.o_busy);
        end
    endtask

    task automatic test_sweep();
        logic [9:0] fr;
        logic [7:0] bv;
        for (int b = 0; b < 255; b++) begin
            bv = 8'(b);
            do_reset(2);
            start1(bv);
            capture1(fr);
            n_tests++;
            if (fr !== {1'b1, bv, 1'b0}) begin
                n_fail++;
                $display("FAIL sweep_frame %02h: got %010b, want %010b", bv, fr, {1'b1, bv, 1'b0});
            end
            step();
            step();
            n_tests++;
            if (bus1.o_serial_out !== 1'b1 || bus1.o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_gap %02h: line=%b busy=%b, want 1 0",
                         bv, bus1.o_serial_out, bus1.o_busy);
            end
        end
    endtask

    task automatic test_tbyte_idle();
        do_reset(2);
        bus1.i_T_byte = 1'b1;
        step();
        bus1.i_T_byte = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (bus1.o_serial_out !== 1'b1 || bus1.o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL tbyte_idle cyc%0d: line=%b busy=%b, want 1 0",
                         i, bus1.o_serial_out, bus1.o_busy);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fr;
        do_reset(2);
        start1(8'hFF);
        repeat (4) step();
        n_tests++;
        if (bus1.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before: busy=%b, want 1", bus1.o_busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (bus1.o_serial_out !== 1'b1 || bus1.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: line=%b busy=%b, want 1 0", bus1.o_serial_out, bus1.o_busy);
        end
        start1(8'h3C);
        capture1(fr);
        n_tests++;
        if (fr !== 10'b1_0011_1100_0) begin
            n_fail++;
            $display("FAIL midrst_refresh: got %010b, want %010b", fr, 10'b1_0011_1100_0);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr;
        do_reset(2);
        start1(8'h5A);
        capture1(fr);
        n_tests++;
        if (fr !== 10'b1_0101_1010_0) begin
            n_fail++;
            $display("FAIL b2b_first: got %010b, want %010b", fr, 10'b1_0101_1010_0);
        end
        step();
        // first IDLE cycle: load 0xC3
        bus1.i_data_bus = 8'hC3; bus1.i_load_xmt_data = 1'b1;
        step();
        // same-cycle load 0x11 with byte_rdy stages the older 0xC3
        bus1.i_data_bus = 8'h11; bus1.i_byte_rdy = 1'b1;
        step();
        bus1.i_load_xmt_data = 1'b0; bus1.i_byte_rdy = 1'b0; bus1.i_T_byte = 1'b1;
        step();
        bus1.i_T_byte = 1'b0;
        // load during SENDING must be ignored
        bus1.i_data_bus = 8'h77; bus1.i_load_xmt_data = 1'b1;
        capture1(fr);
        bus1.i_load_xmt_data = 1'b0;
        n_tests++;
        if (fr !== 10'b1_1100_0011_0) begin
            n_fail++;
            $display("FAIL b2b_second: got %010b, want %010b", fr, 10'b1_1100_0011_0);
        end
        step();
        bus1.i_byte_rdy = 1'b1;
        step();
        bus1.i_byte_rdy = 1'b0; bus1.i_T_byte = 1'b1;
        step();
        bus1.i_T_byte = 1'b0;
        capture1(fr);
        n_tests++;
        if (fr !== 10'b1_0001_0001_0) begin
            n_fail++;
            $display("FAIL b2b_held_data: got %010b, want %010b", fr, 10'b1_0001_0001_0);
        end
        step();
    endtask

    task automatic test_cpb4();
        int exp_seq[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        do_reset(2);
        start4(8'h81);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                n_tests++;
                if (bus4.o_serial_out !== 1'(exp_seq[i]) || bus4.o_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cpb4_bit%0d_cyc%0d: line=%b busy=%b, want %0d 1",
                             i, j, bus4.o_serial_out, bus4.o_busy, exp_seq[i]);
                end
                step();
            end
        end
        n_tests++;
        if (bus4.o_serial_out !== 1'b1 || bus4.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cpb4_done: line=%b busy=%b, want 1 0", bus4.o_serial_out, bus4.o_busy);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_frame_a5();
        test_sweep();
        test_tbyte_idle();
        test_reset_mid_frame();
        test_back_to_back();
        test_cpb4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
